// File: rtl/asrm_ram_sequencer.sv
// asrm_ram_sequencer
//   Shares one synchronous RAM port between the instruction-fetch path and the
//   data path (load/store). Requests that arrive together are served round-robin.
//   Narrow stores (data_width selects 32/16/8 bits and that is below wordsize)
//   are done as read-modify-write so the upper RAM lanes keep their contents.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   IDLE    | waiting for a request; acks of the previous transaction show here
//   RD      | read address on ram_addr; the RAM samples it at the end of this cycle
//   RD_DATA | ram_data_in is valid: finish the load/fetch, or merge a narrow store
//   WR      | ram_write_en high for one cycle; data_ack follows
//
// Ports
//   clk, reset                    clock and asynchronous active-high reset
//   fetch_req/addr/ack/data       instruction fetch channel (always full width)
//   data_req/we/addr/wdata/width  data channel; width 00 full, 01 32b, 10 16b, 11 8b
//   data_ack/rdata                data channel completion; rdata zero-extended if narrow
//   ram_addr/write_en/data_out    registered RAM command outputs
//   ram_data_in                   RAM read data, valid the cycle after ram_addr
module asrm_ram_sequencer #(
    parameter int wordsize = 16,
    parameter int addrsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_req,
    input  logic [addrsize-1:0] fetch_addr,
    output logic                fetch_ack,
    output logic [wordsize-1:0] fetch_data,
    input  logic                data_req,
    input  logic                data_we,
    input  logic [addrsize-1:0] data_addr,
    input  logic [wordsize-1:0] data_wdata,
    input  logic [1:0]          data_width,
    output logic                data_ack,
    output logic [wordsize-1:0] data_rdata,
    output logic [addrsize-1:0] ram_addr,
    output logic                ram_write_en,
    output logic [wordsize-1:0] ram_data_out,
    input  logic [wordsize-1:0] ram_data_in
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_DATA,
        ST_WR
    } state_t;

    // Mask of the lanes an access owns; all ones when the selected width is
    // not smaller than the word, so "narrow" is simply "mask is not all ones".
    function automatic logic [wordsize-1:0] lane_mask(input logic [1:0] width);
        logic [wordsize-1:0] m;
        m = '1;
        for (int i = 0; i < wordsize; i++) begin
            if ((width == 2'b01 && i >= 32) ||
                (width == 2'b10 && i >= 16) ||
                (width == 2'b11 && i >= 8)) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    state_t              state_q, state_d;
    logic                last_data_q, last_data_d;   // 1: last grant went to data
    logic                sel_data_q, sel_data_d;     // current transaction is data
    logic                we_q, we_d;
    logic [wordsize-1:0] wdata_q, wdata_d;
    logic [wordsize-1:0] mask_q, mask_d;
    logic                fetch_ack_q, fetch_ack_d;
    logic                data_ack_q, data_ack_d;
    logic [wordsize-1:0] fetch_data_q, fetch_data_d;
    logic [wordsize-1:0] data_rdata_q, data_rdata_d;
    logic [addrsize-1:0] ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [wordsize-1:0] ram_dout_q, ram_dout_d;

    logic                fetch_pend;
    logic                data_pend;
    logic                grant_data;
    logic [wordsize-1:0] req_mask;
    logic                req_narrow;

    // A requester still holds its request during its own ack cycle; ignore it then.
    assign fetch_pend = fetch_req & ~fetch_ack_q;
    assign data_pend  = data_req & ~data_ack_q;
    assign grant_data = data_pend & (~fetch_pend | ~last_data_q);
    assign req_mask   = lane_mask(data_width);
    assign req_narrow = (req_mask != '1);

    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        sel_data_d   = sel_data_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        fetch_ack_d  = 1'b0;
        data_ack_d   = 1'b0;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = ram_we_q;
        ram_dout_d   = ram_dout_q;

        case (state_q)
            ST_IDLE: begin
                if (fetch_pend || data_pend) begin
                    last_data_d = grant_data;
                    sel_data_d  = grant_data;
                    if (grant_data) begin
                        we_d       = data_we;
                        wdata_d    = data_wdata;
                        mask_d     = req_mask;
                        ram_addr_d = data_addr;
                        if (data_we && !req_narrow) begin
                            ram_dout_d = data_wdata;
                            ram_we_d   = 1'b1;
                            state_d    = ST_WR;
                        end else begin
                            state_d = ST_RD;
                        end
                    end else begin
                        we_d       = 1'b0;
                        mask_d     = '1;
                        ram_addr_d = fetch_addr;
                        state_d    = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (sel_data_q && we_q) begin
                    // Narrow store: keep the RAM's upper lanes, replace the low ones.
                    ram_dout_d = (ram_data_in & ~mask_q) | (wdata_q & mask_q);
                    ram_we_d   = 1'b1;
                    state_d    = ST_WR;
                end else if (sel_data_q) begin
                    data_rdata_d = ram_data_in & mask_q;
                    data_ack_d   = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    fetch_data_d = ram_data_in;
                    fetch_ack_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_WR: begin
                ram_we_d   = 1'b0;
                data_ack_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_data_q  <= 1'b0;
            sel_data_q   <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            mask_q       <= '0;
            fetch_ack_q  <= 1'b0;
            data_ack_q   <= 1'b0;
            fetch_data_q <= '0;
            data_rdata_q <= '0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_dout_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            sel_data_q   <= sel_data_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            fetch_ack_q  <= fetch_ack_d;
            data_ack_q   <= data_ack_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_dout_q   <= ram_dout_d;
        end
    end

    assign fetch_ack    = fetch_ack_q;
    assign fetch_data   = fetch_data_q;
    assign data_ack     = data_ack_q;
    assign data_rdata   = data_rdata_q;
    assign ram_addr     = ram_addr_q;
    assign ram_write_en = ram_we_q;
    assign ram_data_out = ram_dout_q;

endmodule

// File: tb/tb_asrm_ram_sequencer.sv
// Bench for asrm_ram_sequencer: a 16-bit instance checked every cycle against a
// transaction-level model, plus a 32-bit instance for the wide narrow-lane cases.
module tb_asrm_ram_sequencer;

    localparam int W  = 16;
    localparam int WB = 32;
    localparam int A  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 16-bit instance
    logic         fetch_req, fetch_ack, data_req, data_we, data_ack, ram_write_en;
    logic [A-1:0] fetch_addr, data_addr, ram_addr;
    logic [W-1:0] fetch_data, data_wdata, data_rdata, ram_data_out, ram_data_in;
    logic [1:0]   data_width;

    // 32-bit instance
    logic          fetch_req_b, fetch_ack_b, data_req_b, data_we_b, data_ack_b, ram_write_en_b;
    logic [A-1:0]  fetch_addr_b, data_addr_b, ram_addr_b;
    logic [WB-1:0] fetch_data_b, data_wdata_b, data_rdata_b, ram_data_out_b, ram_data_in_b;
    logic [1:0]    data_width_b;

    asrm_ram_sequencer #(.wordsize(W), .addrsize(A)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_width(data_width), .data_ack(data_ack), .data_rdata(data_rdata),
        .ram_addr(ram_addr), .ram_write_en(ram_write_en), .ram_data_out(ram_data_out),
        .ram_data_in(ram_data_in)
    );

    asrm_ram_sequencer #(.wordsize(WB), .addrsize(A)) dut_b (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req_b), .fetch_addr(fetch_addr_b), .fetch_ack(fetch_ack_b), .fetch_data(fetch_data_b),
        .data_req(data_req_b), .data_we(data_we_b), .data_addr(data_addr_b), .data_wdata(data_wdata_b),
        .data_width(data_width_b), .data_ack(data_ack_b), .data_rdata(data_rdata_b),
        .ram_addr(ram_addr_b), .ram_write_en(ram_write_en_b), .ram_data_out(ram_data_out_b),
        .ram_data_in(ram_data_in_b)
    );

    // RAM macros with a preload port used only while reset is held.
    logic [W-1:0]  mem_a [256];
    logic [WB-1:0] mem_b [256];
    logic          pl_en;
    logic [7:0]    pl_addr;
    logic [W-1:0]  pl_da;
    logic [WB-1:0] pl_db;

    always @(posedge clk) begin
        if (pl_en) begin
            mem_a[pl_addr] <= pl_da;
            mem_b[pl_addr] <= pl_db;
        end else begin
            if (ram_write_en)   mem_a[ram_addr[7:0]]   <= ram_data_out;
            if (ram_write_en_b) mem_b[ram_addr_b[7:0]] <= ram_data_out_b;
        end
        ram_data_in   <= mem_a[ram_addr[7:0]];
        ram_data_in_b <= mem_b[ram_addr_b[7:0]];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level model: memory image plus expected completions per channel.
    typedef struct {
        bit           we;
        int           ack_cyc;
        logic [W-1:0] data;
        logic [7:0]   addr;
    } exp_t;

    logic [W-1:0] model_mem [256];
    exp_t fq[$];
    exp_t dq[$];

    function automatic logic [W-1:0] mdl_mask(input logic [1:0] w);
        int n;
        case (w)
            2'b01:   n = 32;
            2'b10:   n = 16;
            2'b11:   n = 8;
            default: n = W;
        endcase
        if (n >= W) return '1;
        return W'((64'd1 << n) - 64'd1);
    endfunction

    // g = cycle number right after the grant edge. Loads/fetches ack on the third
    // edge counting the grant, full stores on the second, narrow stores on the fourth.
    task automatic push_exp(input bit is_data, input bit we, input logic [7:0] a,
                            input logic [W-1:0] wd, input logic [1:0] w, input int g);
        exp_t e;
        logic [W-1:0] m;
        m = mdl_mask(w);
        e.we = is_data && we;
        e.addr = a;
        if (is_data && we) begin
            e.ack_cyc = g + ((m != '1) ? 3 : 1);
            e.data = (model_mem[a] & ~m) | (wd & m);
            model_mem[a] = e.data;
            dq.push_back(e);
        end else begin
            e.ack_cyc = g + 2;
            e.data = model_mem[a] & m;
            if (is_data) dq.push_back(e);
            else fq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (fetch_ack && data_ack) begin
                errors++;
                $display("FAIL ack_overlap: fetch_ack=%b data_ack=%b required not both 1 at cycle %0d",
                         fetch_ack, data_ack, cyc);
            end
            if (ram_write_en) begin
                strobes++;
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL write_strobe: unexpected write addr=%h data=%h at cycle %0d",
                             ram_addr, ram_data_out, cyc);
                end else if (!dq[0].we || dq[0].ack_cyc != cyc + 1 ||
                             ram_addr != {8'h00, dq[0].addr} || ram_data_out != dq[0].data) begin
                    errors++;
                    $display("FAIL write_strobe: got addr=%h data=%h cycle %0d, required addr=%h data=%h cycle %0d",
                             ram_addr, ram_data_out, cyc, dq[0].addr, dq[0].data, dq[0].ack_cyc - 1);
                end
            end
            if (fetch_ack) begin
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL fetch_ack: unexpected ack at cycle %0d", cyc);
                end else begin
                    if (fq[0].ack_cyc != cyc || fetch_data != fq[0].data) begin
                        errors++;
                        $display("FAIL fetch_ack: got data=%h cycle %0d, required data=%h cycle %0d",
                                 fetch_data, cyc, fq[0].data, fq[0].ack_cyc);
                    end
                    void'(fq.pop_front());
                end
            end
            if (data_ack) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL data_ack: unexpected ack at cycle %0d", cyc);
                end else begin
                    if (dq[0].ack_cyc != cyc || (!dq[0].we && data_rdata != dq[0].data)) begin
                        errors++;
                        $display("FAIL data_ack: got rdata=%h cycle %0d, required rdata=%h cycle %0d",
                                 data_rdata, cyc, dq[0].data, dq[0].ack_cyc);
                    end
                    void'(dq.pop_front());
                end
            end
            if (fq.size() > 0 && fq[0].ack_cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL fetch_missing: no ack, required at cycle %0d", fq[0].ack_cyc);
                void'(fq.pop_front());
            end
            if (dq.size() > 0 && dq[0].ack_cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL data_missing: no ack, required at cycle %0d", dq[0].ack_cyc);
                void'(dq.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [W-1:0] da, input logic [WB-1:0] db);
        @(negedge clk);
        pl_en = 1'b1;
        pl_addr = a;
        pl_da = da;
        pl_db = db;
        model_mem[a] = da;
    endtask

    task automatic fetch_drive(input logic [A-1:0] a);
        bit got;
        got = 0;
        fetch_addr = a;
        fetch_req = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (fetch_ack) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: no fetch_ack for addr %h", a);
        end
        @(posedge clk);
        #1 fetch_req = 1'b0;
    endtask

    task automatic data_drive(input bit we, input logic [A-1:0] a, input logic [W-1:0] wd,
                              input logic [1:0] w);
        bit got;
        got = 0;
        data_we = we;
        data_addr = a;
        data_wdata = wd;
        data_width = w;
        data_req = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (data_ack) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL data_timeout: no data_ack for addr %h", a);
        end
        @(posedge clk);
        #1 data_req = 1'b0;
    endtask

    task automatic fetch_one(input logic [A-1:0] a);
        @(negedge clk);
        push_exp(1'b0, 1'b0, a[7:0], '0, 2'b00, cyc + 1);
        fetch_drive(a);
    endtask

    task automatic data_one(input bit we, input logic [A-1:0] a, input logic [W-1:0] wd,
                            input logic [1:0] w);
        @(negedge clk);
        push_exp(1'b1, we, a[7:0], wd, w, cyc + 1);
        data_drive(we, a, wd, w);
    endtask

    // Returns the number of edges from the grant edge (counted as 1) to ack.
    task automatic data_b(input bit we, input logic [A-1:0] a, input logic [WB-1:0] wd,
                          input logic [1:0] w, output int lat);
        bit got;
        got = 0;
        lat = 0;
        @(negedge clk);
        data_we_b = we;
        data_addr_b = a;
        data_wdata_b = wd;
        data_width_b = w;
        data_req_b = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (data_ack_b) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL data_b_timeout: no data_ack for addr %h", a);
        end
        @(posedge clk);
        #1 data_req_b = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int lat;
        reset = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_da = '0; pl_db = '0;
        fetch_req = 0; fetch_addr = '0; data_req = 0; data_we = 0;
        data_addr = '0; data_wdata = '0; data_width = 2'b00;
        fetch_req_b = 0; fetch_addr_b = '0; data_req_b = 0; data_we_b = 0;
        data_addr_b = '0; data_wdata_b = '0; data_width_b = 2'b00;
        repeat (2) @(negedge clk);
        preload(8'h05, 16'h8001, 32'h0);
        preload(8'h06, 16'h0000, 32'hA5A5C3C3);
        preload(8'h07, 16'h0000, 32'h11223344);
        preload(8'h10, 16'hBEEF, 32'h0);
        preload(8'h20, 16'hFFFF, 32'h0);
        preload(8'h30, 16'h1111, 32'h0);
        preload(8'h40, 16'h5A5A, 32'h0);
        preload(8'h41, 16'hC001, 32'h0);
        preload(8'h50, 16'hABCD, 32'h0);
        @(negedge clk);
        pl_en = 1'b0;
        chk("rst_ctrl", {61'd0, fetch_ack, data_ack, ram_write_en}, 64'd0);
        chk("rst_data", {fetch_data, data_rdata, ram_addr, ram_data_out}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Lone fetch
        s0 = strobes;
        fetch_one(16'h0010);
        chk("t1_fetch_data", fetch_data, 16'hBEEF);
        chk("t1_no_strobe", strobes - s0, 0);

        // Simultaneous requests after a fetch grant: data first, then fetch.
        @(negedge clk);
        push_exp(1'b1, 1'b0, 8'h40, '0, 2'b00, cyc + 1);
        push_exp(1'b0, 1'b0, 8'h41, '0, 2'b00, cyc + 4);
        fork
            data_drive(1'b0, 16'h0040, '0, 2'b00);
            fetch_drive(16'h0041);
        join
        chk("t3_data_rdata", data_rdata, 16'h5A5A);
        chk("t3_fetch_data", fetch_data, 16'hC001);

        // 8-bit store merged into 0xFFFF
        data_one(1'b1, 16'h0020, 16'h12AB, 2'b11);
        chk("t2_ram_merge", mem_a[8'h20], 16'hFFAB);

        // 32-bit width on a 16-bit word is full width
        data_one(1'b0, 16'h0005, '0, 2'b01);
        chk("t4_full_load", data_rdata, 16'h8001);

        // 8-bit load, 16-bit full store, full load back
        data_one(1'b0, 16'h0050, '0, 2'b11);
        chk("narrow8_load", data_rdata, 16'h00CD);
        data_one(1'b1, 16'h0050, 16'hBEAD, 2'b10);
        data_one(1'b0, 16'h0050, '0, 2'b00);
        chk("full16_store", mem_a[8'h50], 16'hBEAD);

        // Reset in the middle of a write strobe
        @(negedge clk);
        data_we = 1'b1; data_addr = 16'h0030; data_wdata = 16'h2222; data_width = 2'b00;
        data_req = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_strobe_up", {63'd0, ram_write_en}, 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_strobe_drop", {61'd0, ram_write_en, fetch_ack, data_ack}, 64'd0);
        repeat (2) @(negedge clk);
        chk("t5_ram_kept", mem_a[8'h30], 16'h1111);
        reset = 1'b0;
        push_exp(1'b1, 1'b1, 8'h30, 16'h2222, 2'b00, cyc + 1);
        data_drive(1'b1, 16'h0030, 16'h2222, 2'b00);
        chk("t5_regrant_write", mem_a[8'h30], 16'h2222);

        // 32-bit instance: 16-bit load, 8-bit store, 32-bit full load
        data_b(1'b0, 16'h0006, '0, 2'b10, lat);
        chk("t6_rdata", data_rdata_b, 32'h0000C3C3);
        chk("t6_latency", lat, 3);
        data_b(1'b1, 16'h0007, 32'hFFFFFFEE, 2'b11, lat);
        chk("b_store_latency", lat, 4);
        chk("b_store_merge", mem_b[8'h07], 32'h112233EE);
        data_b(1'b0, 16'h0007, '0, 2'b01, lat);
        chk("b_full_load", data_rdata_b, 32'h112233EE);

        repeat (5) @(negedge clk);
        chk("queues_drained", fq.size() + dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
